// File: rtl/dbuf_pkg.sv
// dbuf_pkg: shared FSM type and constants for the USB/AHB byte-buffer arbiter.
// Imported by dbuf_occ_counter and dbuf_arbiter.
package dbuf_pkg;

  localparam int DBUF_DEPTH = 64;
  localparam int OCC_W      = 7;

  localparam logic SRC_AHB = 1'b0;
  localparam logic SRC_USB = 1'b1;

  // USB-served cycles allowed back to back before AHB is forced in
  localparam logic [1:0] FAIR_LIMIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    AHB_ACTIVE = 2'd1,
    AHB_FIN    = 2'd2
  } dbuf_state_e;

endpackage

// File: rtl/dbuf_occ_counter.sv
// dbuf_occ_counter: buffer fill level with full/empty flags.
// Suppresses writes when full and reads when empty, and records that in a sticky flag.
module dbuf_occ_counter
  import dbuf_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             acc_valid,
  input  logic             acc_write,
  output logic             acc_ok,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             ovf_udf
);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    full   = (occ_q == OCC_W'(DBUF_DEPTH));
    empty  = (occ_q == '0);
    acc_ok = acc_valid && !(acc_write ? full : empty);
    occ_d  = occ_q;
    ovf_d  = ovf_q;
    if (clear) begin
      occ_d = '0;
      ovf_d = 1'b0;
    end else if (acc_ok) begin
      occ_d = acc_write ? occ_q + OCC_W'(1) : occ_q - OCC_W'(1);
    end else if (acc_valid) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_d;
    end
  end

  assign occupancy = occ_q;
  assign ovf_udf   = ovf_q;

endmodule

// File: rtl/dbuf_arbiter.sv
// dbuf_arbiter: one-byte-per-cycle arbiter for a shared buffer port between
// USB store/get pulses and byte-serialised AHB word transfers.
module dbuf_arbiter
  import dbuf_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             ahb_req,
  input  logic             ahb_write,
  input  logic [1:0]       ahb_size,
  input  logic             usb_store,
  input  logic             usb_get,
  output logic             port_en,
  output logic             port_write,
  output logic             port_src,
  output logic [1:0]       byte_lane,
  output logic             ahb_done,
  output logic             ahb_err,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             usb_lost,
  output logic             ovf_udf
);

  dbuf_state_e state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        err_q, err_d;
  logic        store_pend_q, store_pend_d;
  logic        get_pend_q, get_pend_d;
  logic        lost_q, lost_d;
  logic [1:0]  fair_q, fair_d;
  logic        port_en_q, port_en_d;
  logic        port_write_q, port_write_d;
  logic        port_src_q, port_src_d;
  logic [1:0]  lane_out_q, lane_out_d;
  logic        done_q, done_d;
  logic        done_err_q, done_err_d;

  logic ahb_want, fair_force;
  logic grant_store, grant_get, grant_ahb;
  logic acc_valid, acc_write, acc_ok;

  // Arbitration works purely on registered state; clear blocks every grant.
  always_comb begin
    ahb_want    = (state_q == AHB_ACTIVE) && !clear;
    fair_force  = ahb_want && (fair_q == FAIR_LIMIT);
    grant_store = !clear && store_pend_q && !fair_force;
    grant_get   = !clear && get_pend_q && !store_pend_q && !fair_force;
    grant_ahb   = ahb_want && (fair_force || (!store_pend_q && !get_pend_q));
    acc_valid   = grant_store || grant_get || grant_ahb;
    acc_write   = grant_store || (grant_ahb && wr_q);
  end

  dbuf_occ_counter u_occ (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .acc_valid (acc_valid),
    .acc_write (acc_write),
    .acc_ok    (acc_ok),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty),
    .ovf_udf   (ovf_udf)
  );

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    size_d       = size_q;
    lane_d       = lane_q;
    err_d        = err_q;
    store_pend_d = store_pend_q;
    get_pend_d   = get_pend_q;
    lost_d       = lost_q;
    fair_d       = fair_q;
    port_en_d    = acc_ok;
    port_write_d = acc_ok && acc_write;
    port_src_d   = (acc_ok && (grant_store || grant_get)) ? SRC_USB : SRC_AHB;
    lane_out_d   = (acc_ok && grant_ahb) ? lane_q : 2'd0;
    done_d       = 1'b0;
    done_err_d   = 1'b0;

    // A pulse that finds its flag already set is lost, even if that flag is served now.
    if (clear) begin
      store_pend_d = 1'b0;
      get_pend_d   = 1'b0;
      lost_d       = 1'b0;
      fair_d       = 2'd0;
    end else begin
      if (grant_store) store_pend_d = 1'b0;
      if (grant_get)   get_pend_d   = 1'b0;
      if (usb_store) begin
        if (store_pend_q) lost_d = 1'b1;
        else              store_pend_d = 1'b1;
      end
      if (usb_get) begin
        if (get_pend_q) lost_d = 1'b1;
        else            get_pend_d = 1'b1;
      end
      if (!ahb_want || grant_ahb)   fair_d = 2'd0;
      else if (fair_q != FAIR_LIMIT) fair_d = fair_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (ahb_req) begin
          state_d = AHB_ACTIVE;
          wr_d    = ahb_write;
          size_d  = ahb_size;
          lane_d  = 2'd0;
          err_d   = 1'b0;
        end
      end
      AHB_ACTIVE: begin
        if (clear) begin
          state_d = AHB_FIN;
          err_d   = 1'b1;
        end else if (grant_ahb) begin
          if (!acc_ok) err_d = 1'b1;
          if (lane_q == size_q) state_d = AHB_FIN;
          else                  lane_d  = lane_q + 2'd1;
        end
      end
      AHB_FIN: begin
        done_d     = 1'b1;
        done_err_d = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      lane_q       <= 2'd0;
      err_q        <= 1'b0;
      store_pend_q <= 1'b0;
      get_pend_q   <= 1'b0;
      lost_q       <= 1'b0;
      fair_q       <= 2'd0;
      port_en_q    <= 1'b0;
      port_write_q <= 1'b0;
      port_src_q   <= 1'b0;
      lane_out_q   <= 2'd0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      err_q        <= err_d;
      store_pend_q <= store_pend_d;
      get_pend_q   <= get_pend_d;
      lost_q       <= lost_d;
      fair_q       <= fair_d;
      port_en_q    <= port_en_d;
      port_write_q <= port_write_d;
      port_src_q   <= port_src_d;
      lane_out_q   <= lane_out_d;
      done_q       <= done_d;
      done_err_q   <= done_err_d;
    end
  end

  assign port_en    = port_en_q;
  assign port_write = port_write_q;
  assign port_src   = port_src_q;
  assign byte_lane  = lane_out_q;
  assign ahb_done   = done_q;
  assign ahb_err    = done_err_q;
  assign usb_lost   = lost_q;

endmodule

// File: tb/tb_dbuf_arbiter.sv
// tb_dbuf_arbiter: directed scenarios plus a randomized transaction-level
// occupancy model for dbuf_arbiter.
module tb_dbuf_arbiter;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       clear = 1'b0;
  logic       ahb_req = 1'b0;
  logic       ahb_write = 1'b0;
  logic [1:0] ahb_size = 2'd0;
  logic       usb_store = 1'b0;
  logic       usb_get = 1'b0;
  logic       port_en, port_write, port_src;
  logic [1:0] byte_lane;
  logic       ahb_done, ahb_err;
  logic [6:0] occupancy;
  logic       full, empty, usb_lost, ovf_udf;

  int   n_checks = 0;
  int   n_fail = 0;
  int   model_occ = 0;
  logic model_ovf = 1'b0;

  int   ahb_cyc[$];
  int   ahb_lane[$];
  int   ahb_wr[$];
  int   usb_cyc[$];
  int   done_at = -1;
  logic done_err = 1'b0;

  dbuf_arbiter dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (clear),
    .ahb_req    (ahb_req),
    .ahb_write  (ahb_write),
    .ahb_size   (ahb_size),
    .usb_store  (usb_store),
    .usb_get    (usb_get),
    .port_en    (port_en),
    .port_write (port_write),
    .port_src   (port_src),
    .byte_lane  (byte_lane),
    .ahb_done   (ahb_done),
    .ahb_err    (ahb_err),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .usb_lost   (usb_lost),
    .ovf_udf    (ovf_udf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] out_vec();
    return {port_en, port_write, port_src, byte_lane, ahb_done, ahb_err,
            occupancy, full, empty, usb_lost, ovf_udf};
  endfunction

  // Cycle numbers are relative to the cycle in which ahb_req is first driven.
  task automatic run_ahb(input logic wr, input logic [1:0] sz);
    ahb_cyc.delete();
    ahb_lane.delete();
    ahb_wr.delete();
    usb_cyc.delete();
    done_at   = -1;
    done_err  = 1'b0;
    ahb_write = wr;
    ahb_size  = sz;
    ahb_req   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (port_en && port_src == 1'b0) begin
        ahb_cyc.push_back(c);
        ahb_lane.push_back(int'(byte_lane));
        ahb_wr.push_back(int'(port_write));
      end
      if (port_en && port_src == 1'b1) usb_cyc.push_back(c);
      if (ahb_done) begin
        done_at  = c;
        done_err = ahb_err;
        ahb_req  = 1'b0;
        break;
      end
    end
    ahb_req = 1'b0;
    n_checks++;
    if (done_at < 0) begin
      n_fail++;
      $display("[TB] FAIL ahb_timeout: got no ahb_done, expected one within 40 cycles");
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_occ = 0;
    model_ovf = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick();
    n_checks++;
    if (out_vec() !== 18'h00004) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", out_vec(), 18'h00004);
    end
    n_rst = 1'b1;
    model_occ = 0;
    model_ovf = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (out_vec() !== 18'h00004) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got %h expected %h", out_vec(), 18'h00004);
    end
  endtask

  task automatic test_ahb_write();
    run_ahb(1'b1, 2'd3);
    n_checks++;
    if (ahb_cyc.size() != 4) begin
      n_fail++;
      $display("[TB] FAIL ahb_wr_count: got %0d expected 4", ahb_cyc.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= ahb_cyc.size() || ahb_cyc[i] != 2 + i || ahb_lane[i] != i || ahb_wr[i] != 1) begin
        n_fail++;
        $display("[TB] FAIL ahb_wr_byte%0d: got cycle %0d lane %0d expected cycle %0d lane %0d",
                 i, (i < ahb_cyc.size()) ? ahb_cyc[i] : -1, (i < ahb_lane.size()) ? ahb_lane[i] : -1, 2 + i, i);
      end
    end
    n_checks++;
    if (done_at != 6 || done_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ahb_wr_done: got cycle %0d err %0b expected cycle 6 err 0", done_at, done_err);
    end
    model_occ += 4;
    n_checks++;
    if (occupancy !== 7'(model_occ)) begin
      n_fail++;
      $display("[TB] FAIL ahb_wr_occ: got %0d expected %0d", occupancy, model_occ);
    end
  endtask

  task automatic test_dual_pulse();
    usb_store = 1'b1;
    tick();
    usb_store = 1'b0;
    tick();
    model_occ += 1;
    n_checks++;
    if ({port_en, port_src, port_write} !== 3'b111 || occupancy !== 7'(model_occ)) begin
      n_fail++;
      $display("[TB] FAIL single_store: got en/src/wr %b occ %0d expected 111 occ %0d",
               {port_en, port_src, port_write}, occupancy, model_occ);
    end
    usb_store = 1'b1;
    usb_get   = 1'b1;
    tick();
    usb_store = 1'b0;
    usb_get   = 1'b0;
    tick();
    n_checks++;
    if ({port_en, port_src, port_write} !== 3'b111 || occupancy !== 7'(model_occ + 1)) begin
      n_fail++;
      $display("[TB] FAIL dual_store_first: got en/src/wr %b occ %0d expected 111 occ %0d",
               {port_en, port_src, port_write}, occupancy, model_occ + 1);
    end
    tick();
    n_checks++;
    if ({port_en, port_src, port_write} !== 3'b110 || occupancy !== 7'(model_occ)) begin
      n_fail++;
      $display("[TB] FAIL dual_get_second: got en/src/wr %b occ %0d expected 110 occ %0d",
               {port_en, port_src, port_write}, occupancy, model_occ);
    end
  endtask

  // USB pulses every cycle while a 4-byte AHB transfer runs; AHB must still get through.
  task automatic test_fairness(input logic with_get, input logic wr);
    int bad = 0;
    done_at = -1;
    fork
      run_ahb(wr, 2'd3);
      begin
        usb_store = 1'b1;
        usb_get   = with_get;
        for (int k = 0; k < 45 && done_at < 0; k++) tick();
        usb_store = 1'b0;
        usb_get   = 1'b0;
      end
    join
    n_checks++;
    if (ahb_cyc.size() != 4) begin
      n_fail++;
      $display("[TB] FAIL fair_count_g%0b: got %0d AHB bytes expected 4", with_get, ahb_cyc.size());
    end
    for (int i = 0; i < ahb_cyc.size(); i++) begin
      if (ahb_lane[i] != i || ahb_wr[i] != int'(wr)) bad++;
      if (i == 0 && ahb_cyc[0] > 4) bad++;
      if (i > 0 && ahb_cyc[i] - ahb_cyc[i-1] > 3) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL fair_spacing_g%0b: got %0d ordering/spacing violations expected 0", with_get, bad);
    end
    n_checks++;
    if (done_err !== 1'b0 || usb_lost !== 1'b1 || usb_cyc.size() < 3) begin
      n_fail++;
      $display("[TB] FAIL fair_status_g%0b: got err %0b lost %0b usb_bytes %0d expected err 0 lost 1 usb_bytes>=3",
               with_get, done_err, usb_lost, usb_cyc.size());
    end
    do_clear();
    n_checks++;
    if (port_en !== 1'b0 || occupancy !== 7'd0 || empty !== 1'b1 || usb_lost !== 1'b0 || ovf_udf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL clear_flush_g%0b: got en %0b occ %0d empty %0b lost %0b ovf %0b expected 0 0 1 0 0",
               with_get, port_en, occupancy, empty, usb_lost, ovf_udf);
    end
  endtask

  task automatic test_full();
    int bad = 0;
    for (int k = 0; k < 16; k++) begin
      run_ahb(1'b1, 2'd3);
      if (done_err !== 1'b0 || ahb_cyc.size() != 4) bad++;
    end
    n_checks++;
    if (bad != 0 || occupancy !== 7'd64 || full !== 1'b1 || empty !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fill_64: got bad %0d occ %0d full %0b expected bad 0 occ 64 full 1", bad, occupancy, full);
    end
    run_ahb(1'b1, 2'd1);
    n_checks++;
    if (ahb_cyc.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL full_no_port: got %0d AHB bytes expected 0", ahb_cyc.size());
    end
    n_checks++;
    if (done_at != 4 || done_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL full_done: got cycle %0d err %0b expected cycle 4 err 1", done_at, done_err);
    end
    n_checks++;
    if (ovf_udf !== 1'b1 || occupancy !== 7'd64) begin
      n_fail++;
      $display("[TB] FAIL full_status: got ovf %0b occ %0d expected ovf 1 occ 64", ovf_udf, occupancy);
    end
    usb_store = 1'b1;
    tick();
    usb_store = 1'b0;
    tick();
    n_checks++;
    if (port_en !== 1'b0 || occupancy !== 7'd64) begin
      n_fail++;
      $display("[TB] FAIL full_usb_store: got en %0b occ %0d expected en 0 occ 64", port_en, occupancy);
    end
    usb_get = 1'b1;
    tick();
    usb_get = 1'b0;
    tick();
    n_checks++;
    if ({port_en, port_src, port_write} !== 3'b110 || occupancy !== 7'd63 || full !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL get_from_full: got en/src/wr %b occ %0d expected 110 occ 63", {port_en, port_src, port_write}, occupancy);
    end
    do_clear();
  endtask

  task automatic test_clear_mid();
    fork
      run_ahb(1'b1, 2'd3);
      begin
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
      end
    join
    n_checks++;
    if (ahb_cyc.size() != 2 || done_at != 5 || done_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL clear_mid_abort: got bytes %0d done cycle %0d err %0b expected bytes 2 cycle 5 err 1",
               ahb_cyc.size(), done_at, done_err);
    end
    n_checks++;
    if (occupancy !== 7'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL clear_mid_occ: got %0d expected 0", occupancy);
    end
    model_occ = 0;
    model_ovf = 1'b0;
    run_ahb(1'b1, 2'd0);
    model_occ = 1;
    n_checks++;
    if (ahb_cyc.size() != 1 || done_at != 3 || done_err !== 1'b0 || occupancy !== 7'd1) begin
      n_fail++;
      $display("[TB] FAIL after_clear_xfer: got bytes %0d done cycle %0d err %0b occ %0d expected 1 3 0 1",
               ahb_cyc.size(), done_at, done_err, occupancy);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    ahb_write = 1'b1;
    ahb_size  = 2'd3;
    ahb_req   = 1'b1;
    repeat (3) tick();
    #2;
    n_rst   = 1'b0;
    ahb_req = 1'b0;
    #1;
    n_checks++;
    if (out_vec() !== 18'h00004) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_outputs: got %h expected %h", out_vec(), 18'h00004);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ahb_done !== 1'b0) seen_done++;
    end
    n_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ahb_done !== 1'b0) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_no_done: got %0d done pulses expected 0", seen_done);
    end
    model_occ = 0;
    model_ovf = 1'b0;
    run_ahb(1'b1, 2'd3);
    model_occ = 4;
    n_checks++;
    if (ahb_cyc.size() != 4 || done_at != 6 || done_err !== 1'b0 || occupancy !== 7'd4) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_recover: got bytes %0d done cycle %0d err %0b occ %0d expected 4 6 0 4",
               ahb_cyc.size(), done_at, done_err, occupancy);
    end
  endtask

  // Isolated operations against a saturating byte-count model.
  task automatic test_random();
    int   op;
    logic wr;
    logic [1:0] sz;
    logic ok;
    logic exp_err;
    int   exp_lane[$];
    int   bad;
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 3));
      if (op <= 1) begin
        wr = (op == 0);
        ok = wr ? (model_occ < 64) : (model_occ > 0);
        if (wr) usb_store = 1'b1;
        else    usb_get   = 1'b1;
        tick();
        usb_store = 1'b0;
        usb_get   = 1'b0;
        tick();
        if (ok) model_occ += wr ? 1 : -1;
        else    model_ovf = 1'b1;
        n_checks++;
        if ({port_en, port_src, port_write} !== {ok, ok, ok & wr} ||
            occupancy !== 7'(model_occ) || ovf_udf !== model_ovf) begin
          n_fail++;
          $display("[TB] FAIL rand_usb%0d: got en/src/wr %b occ %0d ovf %0b expected %b occ %0d ovf %0b",
                   n, {port_en, port_src, port_write}, occupancy, ovf_udf, {ok, ok, ok & wr}, model_occ, model_ovf);
        end
      end else begin
        wr = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 3));
        exp_lane.delete();
        exp_err = 1'b0;
        for (int i = 0; i <= int'(sz); i++) begin
          ok = wr ? (model_occ < 64) : (model_occ > 0);
          if (ok) begin
            exp_lane.push_back(i);
            model_occ += wr ? 1 : -1;
          end else begin
            exp_err   = 1'b1;
            model_ovf = 1'b1;
          end
        end
        run_ahb(wr, sz);
        bad = (ahb_cyc.size() != exp_lane.size()) ? 1 : 0;
        for (int i = 0; i < exp_lane.size() && i < ahb_cyc.size(); i++) begin
          if (ahb_lane[i] != exp_lane[i] || ahb_cyc[i] != 2 + exp_lane[i] || ahb_wr[i] != int'(wr)) bad++;
        end
        n_checks++;
        if (bad != 0 || done_at != int'(sz) + 3 || done_err !== exp_err ||
            occupancy !== 7'(model_occ) || ovf_udf !== model_ovf) begin
          n_fail++;
          $display("[TB] FAIL rand_ahb%0d: got bad %0d done %0d err %0b occ %0d ovf %0b expected bad 0 done %0d err %0b occ %0d ovf %0b",
                   n, bad, done_at, done_err, occupancy, ovf_udf, int'(sz) + 3, exp_err, model_occ, model_ovf);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ahb_write();
    test_dual_pulse();
    test_fairness(1'b0, 1'b0);
    test_fairness(1'b1, 1'b1);
    test_full();
    test_clear_mid();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbuf_arbiter.md
DBUF_ARBITER -- requirements
Module: dbuf_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of buffer bookkeeping
- ahb_req  in  1  AHB-side word request, level, held until ahb_done
- ahb_write  in  1  1 = store TX bytes, 0 = fetch RX bytes
- ahb_size  in  2  bytes in transfer minus one (0..3 = 1..4 bytes)
- usb_store  in  1  1-cycle pulse, RX block has one byte to store
- usb_get  in  1  1-cycle pulse, TX block wants one byte
- port_en  out  1  shared buffer port strobe, one byte per cycle
- port_write  out  1  1 = write, 0 = read
- port_src  out  1  0 = AHB, 1 = USB
- byte_lane  out  2  AHB byte lane of current access (0 when port_src = 1)
- ahb_done  out  1  1-cycle pulse, AHB transfer finished
- ahb_err  out  1  qualifies ahb_done: transfer aborted or a byte suppressed
- occupancy  out  7  buffered bytes, 0..64
- full / empty  out  1 each  occupancy == 64 / occupancy == 0
- usb_lost  out  1  sticky: USB pulse arrived while same-type pending set
- ovf_udf  out  1  sticky: access suppressed due to full/empty
REQ-002 Clock and reset SHALL be as decided: one clock; reset is asynchronous and active-low (clk, n_rst).

Function
REQ-003 usb_store / usb_get SHALL each set a 1-deep pending flag on the next edge; simultaneous pulses both latch.
REQ-004 Pulse while its pending flag is set SHALL be dropped and set usb_lost.
REQ-005 Arbitration (combinational on registered state), one byte per cycle, priority: store-pending > get-pending > AHB byte.
REQ-006 Fairness: after 2 consecutive USB-served cycles with AHB_ACTIVE, next cycle SHALL serve AHB.
REQ-007 port_* outputs SHALL be registered: uncontested USB pulse at cycle t -> port_en at t+2; pending cleared same edge.
REQ-008 FSM states IDLE, AHB_ACTIVE, AHB_FIN; IDLE->AHB_ACTIVE when ahb_req=1, latching ahb_write, ahb_size, lane counter = 0.
REQ-009 AHB_ACTIVE: each AHB-served cycle issues lane = counter then increments; after lane == ahb_size served -> AHB_FIN.
REQ-010 AHB_FIN SHALL pulse ahb_done one cycle and return to IDLE; ahb_req resampled only in IDLE.
REQ-011 Uncontested 4-byte AHB transfer: req seen cycle t, port_en t+2..t+5, ahb_done t+6.
REQ-012 Occupancy SHALL update on the edge port_en rises: +1 write, -1 read; at most +/-1 per cycle.
REQ-013 Write when full or read when empty SHALL be suppressed (no port_en, no count change, lane still advances), setting ovf_udf; for AHB also sets ahb_err for that transfer.
REQ-014 clear SHALL zero occupancy, pendings, usb_lost, ovf_udf, fairness counter; if AHB_ACTIVE, go to AHB_FIN with ahb_err=1; port_en low next cycle.
REQ-015 clear and usb pulse same cycle: clear wins, pulse discarded.

Reset
REQ-016 n_rst low SHALL asynchronously force IDLE, all pendings/counters 0, all outputs 0 except empty = 1.
REQ-017 Reset mid-transfer SHALL abandon it with no ahb_done pulse.

Structure
REQ-018 Package dbuf_pkg SHALL hold: FSM state enum, DBUF_DEPTH = 64, SRC_AHB/SRC_USB encodings.
REQ-019 Occupancy counter with full/empty/suppress logic SHALL be sub-module dbuf_occ_counter; arbitration and FSM in the top.

Verification
REQ-020 Reset, then ahb_req write, ahb_size=3 -> port_en cycles t+2..t+5, lanes 0,1,2,3, ahb_done t+6, ahb_err 0, occupancy 4.
REQ-021 usb_store and usb_get same cycle, occupancy 5 -> store served t+2, get t+3, occupancy 6 then 5.
REQ-022 AHB 4-byte read with usb_store every cycle -> AHB served at least every 3rd cycle, usb_lost = 1, done with lanes in order.
REQ-023 Occupancy 64, AHB write size 1 -> no port_en for AHB, ovf_udf = 1, ahb_done with ahb_err = 1, occupancy stays 64.
REQ-024 clear asserted after second byte of a 4-byte AHB write -> occupancy 0, ahb_done with ahb_err = 1 next cycle, IDLE.
REQ-025 n_rst low mid-transfer -> outputs 0, empty 1, no ahb_done; new request after release completes normally.
